vscale_hpm_counters: RTL



---
 rtl/vscale_hpm_counters_pkg.sv | 41 ++++
 rtl/vscale_hpm_counters_if.sv | 13 +
 rtl/vscale_hpm_counter.sv | 87 ++++++++
 rtl/vscale_hpm_counters.sv | 130 +++++++++++++
 4 files changed

// File: rtl/vscale_hpm_counters_pkg.sv
// Shared constants for the HPM counter bank: CSR command encoding, HPM CSR
// addresses, event-select width and the CSR read-modify-write merge helper.
package vscale_hpm_counters_pkg;

   typedef enum logic [2:0] {
      CSR_IDLE  = 3'd0,
      CSR_READ  = 3'd4,
      CSR_WRITE = 3'd5,
      CSR_SET   = 3'd6,
      CSR_CLEAR = 3'd7
   } csr_cmd_e;

   localparam logic [1:0] PRV_U = 2'd0;

   localparam logic [11:0] CSR_ADDR_MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] CSR_ADDR_MHPMCOUNTER3H = 12'hB83;
   localparam logic [11:0] CSR_ADDR_MHPMEVENT3    = 12'h323;
   localparam logic [11:0] CSR_ADDR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_ADDR_MCOUNTEREN    = 12'h306;
   localparam logic [11:0] CSR_ADDR_HPMCOUNTER3   = 12'hC03;
   localparam logic [11:0] CSR_ADDR_HPMCOUNTER3H  = 12'hC83;

   localparam int HPM_EVSEL_WIDTH = 8;
   // Counter i lives at bit position HPM_FIRST_IDX+i in inhibit/enable masks.
   localparam int HPM_FIRST_IDX   = 3;

   function automatic logic csr_is_write(input logic [2:0] cmd);
      return cmd[1] | cmd[0];
   endfunction

   function automatic logic [31:0] csr_wval(input logic [2:0]  cmd,
                                            input logic [31:0] rdata,
                                            input logic [31:0] wdata);
      case (cmd)
         CSR_SET:   return rdata | wdata;
         CSR_CLEAR: return rdata & ~wdata;
         default:   return wdata;
      endcase
   endfunction

endpackage

// File: rtl/vscale_hpm_counters_if.sv
// CSR request/response bus shared by the main CSR file and the HPM bank.
interface vscale_hpm_counters_if;
   logic        req;
   logic [11:0] addr;
   logic [2:0]  cmd;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        hit;
   logic        illegal_access;

   modport master (output req, addr, cmd, wdata, input rdata, hit, illegal_access);
   modport slave  (input req, addr, cmd, wdata, output rdata, hit, illegal_access);
endinterface

// File: rtl/vscale_hpm_counter.sv
// One HPM counter: event select (WARL), inhibit, CSR write merge and, with
// HPM_OVERFLOW_IRQ_EN defined, the sticky overflow flag (mhpmevent[31]).
module vscale_hpm_counter
   import vscale_hpm_counters_pkg::*;
#(
   parameter int COUNTER_WIDTH = 64,
   parameter int N_EVENTS      = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_EVENTS-1:0]        events_i,
   input  logic                       inhibit_i,
   input  logic                       wen_lo_i,
   input  logic                       wen_hi_i,
   input  logic                       wen_ev_i,
   input  logic [31:0]                wval_i,
   output logic [COUNTER_WIDTH-1:0]   cnt_o,
   output logic [HPM_EVSEL_WIDTH-1:0] evsel_o,
   output logic                       of_o
);

   logic [COUNTER_WIDTH-1:0]   cnt_q, cnt_d;
   logic [HPM_EVSEL_WIDTH-1:0] evsel_q, evsel_d;
   logic                       ev_hit;
   logic                       inc;

   always_comb begin
      ev_hit = 1'b0;
      for (int k = 0; k < N_EVENTS; k++) begin
         if (evsel_q == HPM_EVSEL_WIDTH'(k + 1)) ev_hit = events_i[k];
      end
   end

   // A CSR write to either half drops this cycle's increment.
   assign inc = ev_hit & ~inhibit_i & ~wen_lo_i & ~wen_hi_i;

   always_comb begin
      cnt_d   = cnt_q;
      evsel_d = evsel_q;
      if (wen_lo_i)
         cnt_d[31:0] = wval_i;
      else if (wen_hi_i)
         cnt_d[COUNTER_WIDTH-1:32] = wval_i[COUNTER_WIDTH-33:0];
      else if (inc)
         cnt_d = cnt_q + COUNTER_WIDTH'(1);
      if (wen_ev_i)
         evsel_d = (wval_i[HPM_EVSEL_WIDTH-1:0] > HPM_EVSEL_WIDTH'(N_EVENTS)) ?
                   '0 : wval_i[HPM_EVSEL_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         evsel_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         evsel_q <= evsel_d;
      end
   end

`ifdef HPM_OVERFLOW_IRQ_EN
   logic of_q, of_d;
   logic wrap;

   assign wrap = inc & (&cnt_q);

   // Hardware set beats a coincident software clear.
   always_comb begin
      of_d = of_q;
      if (wen_ev_i) of_d = wval_i[31];
      if (wrap)     of_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) of_q <= 1'b0;
      else       of_q <= of_d;
   end

   assign of_o = of_q;
`else
   assign of_o = 1'b0;
`endif

   assign cnt_o   = cnt_q;
   assign evsel_o = evsel_q;

endmodule

// File: rtl/vscale_hpm_counters.sv
// HPM counter bank beside the main CSR file: address decode, privilege checks,
// mcountinhibit/mcounteren and N counters. Optional HPM_OVERFLOW_IRQ_EN.
module vscale_hpm_counters
   import vscale_hpm_counters_pkg::*;
#(
   parameter int N_COUNTERS    = 4,
   parameter int COUNTER_WIDTH = 64,
   parameter int N_EVENTS      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   vscale_hpm_counters_if.slave  csr,
   input  logic [1:0]            ms_prv,
   input  logic [N_EVENTS-1:0]   events,
   output logic                  overflow_irq
);

   logic [N_EVENTS-1:0]        events_q;
   logic [N_COUNTERS-1:0]      inhibit_q, inhibit_d;
   logic [N_COUNTERS-1:0]      counteren_q, counteren_d;
   logic [COUNTER_WIDTH-1:0]   cnt [N_COUNTERS];
   logic [HPM_EVSEL_WIDTH-1:0] evsel [N_COUNTERS];
   logic [N_COUNTERS-1:0]      of_flag;
   logic [N_COUNTERS-1:0]      wen_lo, wen_hi, wen_ev;
   logic [31:0]                rdata;
   logic [31:0]                wval;
   logic                       hit;
   logic                       user_blocked;
   logic                       is_write;
   logic                       illegal;
   logic                       wen;

   always_comb begin
      hit          = 1'b0;
      rdata        = '0;
      user_blocked = 1'b0;
      if (csr.addr == CSR_ADDR_MCOUNTINHIBIT) begin
         hit   = 1'b1;
         rdata = 32'({inhibit_q, 3'b000});
      end
      if (csr.addr == CSR_ADDR_MCOUNTEREN) begin
         hit   = 1'b1;
         rdata = 32'({counteren_q, 3'b000});
      end
      for (int i = 0; i < N_COUNTERS; i++) begin
         if (csr.addr == CSR_ADDR_MHPMCOUNTER3 + 12'(i) ||
             csr.addr == CSR_ADDR_HPMCOUNTER3 + 12'(i)) begin
            hit   = 1'b1;
            rdata = cnt[i][31:0];
         end
         if (csr.addr == CSR_ADDR_MHPMCOUNTER3H + 12'(i) ||
             csr.addr == CSR_ADDR_HPMCOUNTER3H + 12'(i)) begin
            hit   = 1'b1;
            rdata = 32'(cnt[i][COUNTER_WIDTH-1:32]);
         end
         if (csr.addr == CSR_ADDR_MHPMEVENT3 + 12'(i)) begin
            hit   = 1'b1;
            rdata = {of_flag[i], 23'd0, evsel[i]};
         end
         // User shadows are only reachable when machine mode enabled them.
         if ((csr.addr == CSR_ADDR_HPMCOUNTER3 + 12'(i) ||
              csr.addr == CSR_ADDR_HPMCOUNTER3H + 12'(i)) && !counteren_q[i])
            user_blocked = 1'b1;
      end
   end

   assign is_write = csr_is_write(csr.cmd);
   assign illegal  = csr.req & ((is_write & (csr.addr[11:8] == 4'hC)) |
                                (csr.addr[9:8] > ms_prv) |
                                ((ms_prv == PRV_U) & user_blocked));
   assign wen      = csr.req & is_write & hit & ~illegal;
   assign wval     = csr_wval(csr.cmd, rdata, csr.wdata);

   assign csr.rdata          = rdata;
   assign csr.hit            = hit;
   assign csr.illegal_access = illegal;

   generate
      for (genvar gi = 0; gi < N_COUNTERS; gi++) begin : g_ctr
         assign wen_lo[gi] = wen & (csr.addr == CSR_ADDR_MHPMCOUNTER3 + 12'(gi));
         assign wen_hi[gi] = wen & (csr.addr == CSR_ADDR_MHPMCOUNTER3H + 12'(gi));
         assign wen_ev[gi] = wen & (csr.addr == CSR_ADDR_MHPMEVENT3 + 12'(gi));

         vscale_hpm_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .N_EVENTS      (N_EVENTS)
         ) u_counter (
            .clk       (clk),
            .reset     (reset),
            .events_i  (events_q),
            .inhibit_i (inhibit_q[gi]),
            .wen_lo_i  (wen_lo[gi]),
            .wen_hi_i  (wen_hi[gi]),
            .wen_ev_i  (wen_ev[gi]),
            .wval_i    (wval),
            .cnt_o     (cnt[gi]),
            .evsel_o   (evsel[gi]),
            .of_o      (of_flag[gi])
         );
      end
   endgenerate

   always_comb begin
      inhibit_d   = inhibit_q;
      counteren_d = counteren_q;
      if (wen && csr.addr == CSR_ADDR_MCOUNTINHIBIT)
         inhibit_d = wval[HPM_FIRST_IDX +: N_COUNTERS];
      if (wen && csr.addr == CSR_ADDR_MCOUNTEREN)
         counteren_d = wval[HPM_FIRST_IDX +: N_COUNTERS];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         events_q    <= '0;
         inhibit_q   <= '0;
         counteren_q <= '0;
      end else begin
         events_q    <= events;
         inhibit_q   <= inhibit_d;
         counteren_q <= counteren_d;
      end
   end

`ifdef HPM_OVERFLOW_IRQ_EN
   assign overflow_irq = |of_flag;
`else
   assign overflow_irq = 1'b0;
`endif

endmodule
